// File: rtl/fetch_sequencer.sv
// Fetch engine for the Bat Amateur processor: Moore FSM driving PC/MAR/IR strobes and the execute handshake.
// Optional MEM_READ watchdog is built when MEM_TIMEOUT_EN is defined; otherwise MEM_READ waits forever.
module fetch_sequencer #(
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   RUN,
  input  logic                   MEM_READY,
  input  logic                   EXEC_DONE,
  input  logic                   JUMP,
  input  logic                   HALT_REQ,
  output logic                   PC_ENABLE,
  output logic                   PC_COUNT,
  output logic                   PC_LOAD,
  output logic                   MAR_LOAD,
  output logic                   MEM_RD,
  output logic                   MEM_ENABLE,
  output logic                   IR_LOAD,
  output logic                   EXEC_START,
  output logic                   HALTED,
  output logic                   FAULT,
  output logic [COUNT_WIDTH-1:0] INSTR_COUNT
);

  typedef enum logic [3:0] {
    S_IDLE, S_PC_OUT, S_MEM_READ, S_IR_FETCH, S_EXEC_START,
    S_EXEC_WAIT, S_JUMP_LOAD, S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic pc_enable, pc_count, pc_load, mar_load, mem_rd;
    logic mem_enable, ir_load, exec_start, halted, fault;
  } strobe_t;

`ifdef MEM_TIMEOUT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  // One-hot strobe decode per state; PC_ENABLE and MEM_ENABLE live in different states.
  function automatic strobe_t decode(input state_t s);
    strobe_t o;
    o = '0;
    case (s)
      S_PC_OUT:     begin o.pc_enable = 1'b1; o.mar_load = 1'b1; end
      S_MEM_READ:   o.mem_rd = 1'b1;
      S_IR_FETCH:   begin o.mem_enable = 1'b1; o.ir_load = 1'b1; o.pc_count = 1'b1; end
      S_EXEC_START: o.exec_start = 1'b1;
      S_JUMP_LOAD:  o.pc_load = 1'b1;
      S_HALT:       o.halted = 1'b1;
      S_FAULT:      o.fault = FAULT_EN;
      default:      ;
    endcase
    return o;
  endfunction

  state_t  state, nxt;
  strobe_t strb;
  logic    timeout;

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;

  // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout = (wait_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                               wait_cnt <= '0;
    else if (state == S_PC_OUT)               wait_cnt <= '0;
    else if (state == S_MEM_READ && !MEM_READY) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:       if (RUN) nxt = S_PC_OUT;
      S_PC_OUT:     nxt = S_MEM_READ;
      S_MEM_READ:   if (MEM_READY)    nxt = S_IR_FETCH;
                    else if (timeout) nxt = S_FAULT;
      S_IR_FETCH:   nxt = S_EXEC_START;
      S_EXEC_START: nxt = S_EXEC_WAIT;
      S_EXEC_WAIT:  if (EXEC_DONE) begin
                      if (HALT_REQ)  nxt = S_HALT;
                      else if (JUMP) nxt = S_JUMP_LOAD;
                      else if (RUN)  nxt = S_PC_OUT;
                      else           nxt = S_IDLE;
                    end
      S_JUMP_LOAD:  nxt = RUN ? S_PC_OUT : S_IDLE;
      S_HALT:       nxt = S_HALT;
      S_FAULT:      nxt = S_FAULT;
      default:      nxt = S_IDLE;
    endcase
  end

  // Strobes are registered alongside the state so they are a pure function of it.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      strb        <= '0;
      INSTR_COUNT <= '0;
    end else begin
      state <= nxt;
      strb  <= decode(nxt);
      if (state == S_IR_FETCH) INSTR_COUNT <= INSTR_COUNT + 1'b1;
    end
  end

  assign PC_ENABLE  = strb.pc_enable;
  assign PC_COUNT   = strb.pc_count;
  assign PC_LOAD    = strb.pc_load;
  assign MAR_LOAD   = strb.mar_load;
  assign MEM_RD     = strb.mem_rd;
  assign MEM_ENABLE = strb.mem_enable;
  assign IR_LOAD    = strb.ir_load;
  assign EXEC_START = strb.exec_start;
  assign HALTED     = strb.halted;
  assign FAULT      = strb.fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: strobe sequences, memory stall, jump/halt, RUN drop, async reset, count wrap.
module tb_fetch_sequencer;
  localparam int CW = 4;
  localparam int TO = 5;

  logic gclk = 1'b0;
  logic RESET, RUN, MEM_READY, EXEC_DONE, JUMP, HALT_REQ;
  logic PC_ENABLE, PC_COUNT, PC_LOAD, MAR_LOAD, MEM_RD, MEM_ENABLE, IR_LOAD, EXEC_START, HALTED, FAULT;
  logic [CW-1:0] INSTR_COUNT;

  // {PC_ENABLE,PC_COUNT,PC_LOAD,MAR_LOAD,MEM_RD,MEM_ENABLE,IR_LOAD,EXEC_START,HALTED,FAULT}
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_PCOUT = 10'b1001000000;
  localparam logic [9:0] V_MEMRD = 10'b0000100000;
  localparam logic [9:0] V_IRF   = 10'b0100011000;
  localparam logic [9:0] V_EXST  = 10'b0000000100;
  localparam logic [9:0] V_WAIT  = 10'b0000000000;
  localparam logic [9:0] V_JMP   = 10'b0010000000;
  localparam logic [9:0] V_HALT  = 10'b0000000010;
  localparam logic [9:0] V_FAULT = 10'b0000000001;

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  fetch_sequencer #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut (
    .CLOCK(gclk), .RESET(RESET), .RUN(RUN), .MEM_READY(MEM_READY), .EXEC_DONE(EXEC_DONE),
    .JUMP(JUMP), .HALT_REQ(HALT_REQ), .PC_ENABLE(PC_ENABLE), .PC_COUNT(PC_COUNT),
    .PC_LOAD(PC_LOAD), .MAR_LOAD(MAR_LOAD), .MEM_RD(MEM_RD), .MEM_ENABLE(MEM_ENABLE),
    .IR_LOAD(IR_LOAD), .EXEC_START(EXEC_START), .HALTED(HALTED), .FAULT(FAULT),
    .INSTR_COUNT(INSTR_COUNT)
  );

  wire [9:0] outs = {PC_ENABLE, PC_COUNT, PC_LOAD, MAR_LOAD, MEM_RD, MEM_ENABLE,
                     IR_LOAD, EXEC_START, HALTED, FAULT};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then check strobes and bus exclusivity 1 ns later.
  task automatic step(input string tag, input logic [9:0] exp);
    @(posedge gclk); #1;
    chk(tag, 32'(outs), 32'(exp));
    chk({tag, "_excl"}, 32'(PC_ENABLE & MEM_ENABLE), 32'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    chk("rst_outs", 32'(outs), 32'(V_IDLE));
    chk("rst_cnt", 32'(INSTR_COUNT), 32'd0);
    @(negedge gclk);
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; RUN = 1'b0; MEM_READY = 1'b0; EXEC_DONE = 1'b0; JUMP = 1'b0; HALT_REQ = 1'b0;
    #2;

    // Steady-state: 5-cycle period, count 3 after three IR_FETCH edges
    do_reset();
    RUN = 1'b1; MEM_READY = 1'b1; EXEC_DONE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("ss_pcout", V_PCOUT);
      step("ss_memrd", V_MEMRD);
      step("ss_irf", V_IRF);
      step("ss_exst", V_EXST);
      step("ss_wait", V_WAIT);
    end
    chk("ss_cnt3", 32'(INSTR_COUNT), 32'd3);

    // Memory stall: MEM_READY low for 4 sampled cycles -> MEM_RD 5 cycles, EXEC_START 8 edges out
    do_reset();
    RUN = 1'b1; MEM_READY = 1'b0; EXEC_DONE = 1'b0;
    step("st_pcout", V_PCOUT);
    for (int i = 0; i < 5; i++) step("st_memrd", V_MEMRD);
    MEM_READY = 1'b1;
    step("st_irf", V_IRF);
    step("st_exst", V_EXST);
    // JUMP/HALT_REQ without EXEC_DONE are ignored
    JUMP = 1'b1; HALT_REQ = 1'b1;
    step("st_wait", V_WAIT);
    step("st_wait_hold", V_WAIT);
    HALT_REQ = 1'b0; EXEC_DONE = 1'b1;
    step("jmp_load", V_JMP);
    JUMP = 1'b0; EXEC_DONE = 1'b0;
    step("jmp_pcout", V_PCOUT);
    step("jmp_memrd", V_MEMRD);
    step("jmp_irf", V_IRF);
    JUMP = 1'b1; HALT_REQ = 1'b1; EXEC_DONE = 1'b1;
    step("h_exst", V_EXST);
    step("h_wait", V_WAIT);
    step("h_halt", V_HALT);
    RUN = 1'b1; JUMP = 1'b0; HALT_REQ = 1'b0;
    for (int i = 0; i < 3; i++) step("h_stay", V_HALT);
    chk("h_cnt2", 32'(INSTR_COUNT), 32'd2);
    #2;
    do_reset();

    // RUN dropped in MEM_READ: instruction completes, then IDLE
    RUN = 1'b1; MEM_READY = 1'b0; EXEC_DONE = 1'b1; JUMP = 1'b0; HALT_REQ = 1'b0;
    step("rd_pcout", V_PCOUT);
    step("rd_memrd", V_MEMRD);
    RUN = 1'b0; MEM_READY = 1'b1;
    step("rd_irf", V_IRF);
    step("rd_exst", V_EXST);
    step("rd_wait", V_WAIT);
    for (int i = 0; i < 3; i++) step("rd_idle", V_IDLE);
    chk("rd_cnt1", 32'(INSTR_COUNT), 32'd1);

    // Async reset mid-IR_FETCH clears outputs and count at once
    RUN = 1'b1;
    step("ra_pcout", V_PCOUT);
    step("ra_memrd", V_MEMRD);
    step("ra_irf", V_IRF);
    #2;
    do_reset();

`ifdef MEM_TIMEOUT_EN
    RUN = 1'b1; MEM_READY = 1'b0; EXEC_DONE = 1'b0;
    step("to_pcout", V_PCOUT);
    for (int i = 0; i < TO; i++) step("to_memrd", V_MEMRD);
    step("to_fault", V_FAULT);
    MEM_READY = 1'b1;
    for (int i = 0; i < 3; i++) step("to_stay", V_FAULT);
`else
    RUN = 1'b1; MEM_READY = 1'b0; EXEC_DONE = 1'b0;
    step("nt_pcout", V_PCOUT);
    for (int i = 0; i < 20; i++) step("nt_memrd", V_MEMRD);
`endif
    #2;
    do_reset();

    // 17 fetches into a 4-bit counter wrap to 1
    RUN = 1'b1; MEM_READY = 1'b1; EXEC_DONE = 1'b1;
    for (int i = 0; i < 17 * 5; i++) begin
      @(posedge gclk); #1;
    end
    chk("wrap_state", 32'(outs), 32'(V_WAIT));
    chk("wrap_cnt", 32'(INSTR_COUNT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control-side fetch engine for the Bat Amateur processor. Drives the LOAD/ENABLE/COUNT strobes of the program-counter, memory-address and instruction registers on the shared data bus, handshakes with memory for the instruction read, then hands off to the execute unit and waits for completion. Sits directly upstream of the register blocks: every strobe it emits is consumed by a register instance during the following rising clock edge.

## Interface
- COUNT_WIDTH, 16: width of the retired-instruction counter.
- TIMEOUT_CYCLES, 255: maximum MEM_READ wait before fault; used only with the timeout feature.
- TIMEOUT_WIDTH, 8: width of the wait counter; TIMEOUT_CYCLES must be below 2^TIMEOUT_WIDTH.
- CLOCK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  reset, asynchronous, active-low.
- RUN  input  1  level; high permits new fetches.
- MEM_READY  input  1  memory has valid read data, sampled in MEM_READ.
- EXEC_DONE  input  1  execute unit finished, sampled in EXEC_WAIT.
- JUMP  input  1  qualifies EXEC_DONE: a PC reload is required.
- HALT_REQ  input  1  qualifies EXEC_DONE: the instruction was HALT.
- PC_ENABLE, PC_COUNT, PC_LOAD  output  1 each  program-counter strobes.
- MAR_LOAD  output  1  memory-address register load.
- MEM_RD  output  1  memory read request.
- MEM_ENABLE  output  1  memory drives the data bus.
- IR_LOAD  output  1  instruction register load.
- EXEC_START  output  1  one-cycle pulse to the execute unit.
- HALTED  output  1  sticky halt indication.
- FAULT  output  1  sticky memory-timeout indication.
- INSTR_COUNT  output  COUNT_WIDTH  number of instructions fetched.

## Operation
- Moore FSM. Every output is decoded from the state register only. No output depends combinationally on an input.
- States and outputs:
  - IDLE: none.
  - PC_OUT: PC_ENABLE, MAR_LOAD.
  - MEM_READ: MEM_RD.
  - IR_FETCH: MEM_ENABLE, IR_LOAD, PC_COUNT.
  - EXEC_START: EXEC_START.
  - EXEC_WAIT: none.
  - JUMP_LOAD: PC_LOAD.
  - HALT: HALTED.
  - FAULT: FAULT.
- Transitions:
  - IDLE→PC_OUT when RUN=1.
  - PC_OUT→MEM_READ unconditionally.
  - MEM_READ→IR_FETCH when MEM_READY=1; otherwise stay.
  - IR_FETCH→EXEC_START unconditionally.
  - EXEC_START→EXEC_WAIT unconditionally.
  - EXEC_WAIT with EXEC_DONE=1, first match wins:
    1. HALT_REQ=1 → HALT.
    2. JUMP=1 → JUMP_LOAD.
    3. RUN=1 → PC_OUT.
    4. Otherwise → IDLE.
  - EXEC_WAIT stays put while EXEC_DONE=0.
  - JUMP_LOAD→PC_OUT if RUN=1, else IDLE.
  - HALT and FAULT are absorbing; only RESET exits them.
- Bus exclusivity: PC_ENABLE and MEM_ENABLE are never high in the same cycle. The block never asserts any ENABLE while a LOAD of the same register is high.
- INSTR_COUNT increments by 1 on every clock edge where the state is IR_FETCH. It wraps from all-ones to 0 with no flag.
- RUN deasserted mid-fetch does not abort; the current instruction completes through EXEC_WAIT.
- JUMP or HALT_REQ without EXEC_DONE are ignored.

## Timing
- Reset: all state and outputs clear asynchronously.
  - State goes to IDLE.
  - Every strobe, HALTED and FAULT go to 0.
  - INSTR_COUNT goes to 0.
  - Wait counter goes to 0.
- Reset release: the first transition happens on the first rising edge with RESET=1.
- Reset mid-operation abandons the cycle in progress. No strobe is held over.
- Fetch latency with MEM_READY already high: PC_OUT, MEM_READ, IR_FETCH, EXEC_START = 4 cycles from leaving IDLE to the EXEC_START pulse.
- Each cycle MEM_READY stays low adds one cycle.
- Minimum instruction period with EXEC_DONE high on EXEC_WAIT entry: 5 cycles, plus 1 for a jump.
- Outputs change on the edge following the sampled condition. Registers respond one edge later.

## Configuration
- Macro MEM_TIMEOUT_EN.
- Defined:
  - The wait counter clears on entering MEM_READY and counts each cycle spent in MEM_READ with MEM_READY=0.
  - When the count reaches TIMEOUT_CYCLES with MEM_READY still 0, the next state is FAULT.
  - MEM_READY=1 on that same cycle wins and goes to IR_FETCH.
- Not defined:
  - No wait counter is built.
  - MEM_READ waits indefinitely.
  - FAULT is tied to 0 and the FAULT state is unreachable.

## Test plan
- Reset then RUN=1, MEM_READY=1, EXEC_DONE=1, JUMP=0, HALT_REQ=0 → strobes repeat every 5 cycles; INSTR_COUNT=3 after three IR_FETCH cycles; PC_ENABLE&MEM_ENABLE never both 1.
- MEM_READY held low 4 cycles in MEM_READ → MEM_RD high 5 cycles, EXEC_START 8 cycles after leaving IDLE.
- EXEC_DONE=1 with JUMP=1 → exactly one PC_LOAD cycle, then PC_OUT; with HALT_REQ=1 and JUMP=1 simultaneously → HALTED=1, no PC_LOAD, stays until RESET.
- RUN dropped during MEM_READ → instruction completes, FSM returns to IDLE after EXEC_DONE; no further MAR_LOAD.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=3, MEM_READY=0 forever → FAULT=1 after 3 waiting cycles, all strobes 0; without macro → MEM_RD stays high, FAULT=0.
- RESET asserted mid-IR_FETCH and during HALT → all outputs 0 immediately (asynchronously), INSTR_COUNT=0; COUNT_WIDTH=4 run of 17 fetches → INSTR_COUNT=1.
